motor_pwm_ramp: RTL and testbench
=================================

// Module: motor_pwm_ramp
// PURPOSE
//  Drives the H-bridge enable pin downstream of the dead-time gated direction/enable stage.
//  Converts that stage's enable level into a PWM waveform with a programmable duty target.
//  Soft-starts and soft-stops the motor with a duty ramp.
//  Direction reaches the bridge only at zero duty, so reversal never happens under load.
// PARAMETERS
//  PRESCALE  125     CLK cycles per PWM tick (>=1); PWM period = 255*PRESCALE cycles
//  RAMP_DIV  4       PWM periods per ramp step (>=1)
//  RAMP_STEP 8'd1    duty increment/decrement per ramp step (1..255)
// PORTS
//  CLK          in   1  system clock
//  RST_N        in   1  asynchronous active-low reset
//  EN_IN        in   1  run request (dead-time gated enable from upstream)
//  DIR_IN       in   1  requested direction
//  DUTY_TARGET  in   8  target duty, 0=off, 255=100%
//  PWM_OUT      out  1  bridge enable, PWM
//  DIR_OUT      out  1  bridge direction, changes only when DUTY_NOW==0
//  DUTY_NOW     out  8  duty currently applied
//  BUSY         out  1  high in any state except IDLE
// BEHAVIOUR
//  Reset (async, RST_N=0): PWM_OUT=0, DIR_OUT=0, DUTY_NOW=0, BUSY=0, state IDLE, all counters 0.
//  Tick counter: counts 0..PRESCALE-1 and wraps.
//  Phase: 8-bit, advances on tick wrap through 0..254, then back to 0.
//  Period boundary: the cycle in which phase wraps 254->0.
//  PWM_OUT is registered: PWM_OUT = (phase < duty_lat). duty_lat is DUTY_NOW sampled at the period boundary.
//    - Duty 0 gives constant low. Duty 255 gives constant high. No mid-period glitches.
//  DUTY_NOW changes only at period boundaries, and only once every RAMP_DIV periods (ramp divider).
//  Ramp arithmetic: saturating. Step up = min(DUTY_NOW+RAMP_STEP, tgt). Step down = max(DUTY_NOW-RAMP_STEP, tgt).
//    - Intermediate values are computed 9 bits wide; no wrap-around.
//  FSM, evaluated every CLK:
//    IDLE:      DUTY_NOW=0.
//               - EN_IN=1 and DUTY_TARGET!=0: DIR_OUT<=DIR_IN, go RAMP_UP.
//    RAMP_UP:   step toward DUTY_TARGET.
//               - Reaching DUTY_TARGET: go RUN.
//    RUN:       track DUTY_TARGET. Ramp up or down as needed, staying in RUN.
//    RAMP_DOWN: step toward 0.
//               - At 0: go IDLE. IDLE may restart the next cycle.
//    From RAMP_UP or RUN:
//      - EN_IN=0, or DIR_IN!=DIR_OUT, or DUTY_TARGET==0: go RAMP_DOWN.
//  Simultaneous events: EN_IN=0 has priority over a direction change. Both result in RAMP_DOWN.
//  A direction request seen in RAMP_DOWN is applied only on the IDLE->RAMP_UP transition.
//  DUTY_TARGET changing mid-ramp: the new value applies at the next ramp step.
//  RST_N low mid-operation: outputs drop to reset values immediately (async). No ramp-down.
// CONFIGURATION
//  MOTOR_PWM_RAMP_EN defined:
//    - Ramp behaviour exactly as above.
//  MOTOR_PWM_RAMP_EN undefined:
//    - RAMP_DIV and RAMP_STEP are ignored.
//    - DUTY_NOW jumps straight to its destination (target, or 0) at the next period boundary.
//    - The FSM and the zero-duty gating of direction are unchanged.
// STRUCTURE
//  Package motor_pkg: FSM state encoding (IDLE/RAMP_UP/RUN/RAMP_DOWN), DUTY_W=8, PHASE_MAX=8'd254.
//  Sub-module pwm_core: prescaler, phase counter, duty latch, compare.
//    - Outputs: PWM_OUT and a one-cycle period_end strobe.
//  Top level holds the FSM, ramp divider, DUTY_NOW and DIR_OUT.
// TESTING (bench: PRESCALE=1, RAMP_DIV=1, RAMP_STEP=1, MOTOR_PWM_RAMP_EN defined unless noted)
//  1. Reset, then EN_IN=1, DUTY_TARGET=4
//       -> DUTY_NOW counts 1,2,3,4 on successive 255-cycle boundaries, then RUN.
//       -> PWM_OUT high for exactly 4 of each 255 cycles.
//  2. In RUN at duty 4, DIR_IN toggles
//       -> ramps 3,2,1,0, then IDLE.
//       -> DIR_OUT toggles on the IDLE->RAMP_UP cycle while DUTY_NOW==0, then ramps back to 4.
//  3. DUTY_TARGET=255, RAMP_STEP=100
//       -> DUTY_NOW 100,200,255 (saturates, no wrap).
//       -> PWM_OUT constant high at 255.
//  4. EN_IN drops while a DIR_IN change is pending
//       -> RAMP_DOWN to 0, IDLE, BUSY=0.
//       -> DIR_OUT unchanged while EN_IN stays 0.
//  5. RST_N pulsed low mid-RUN, asynchronously between clock edges
//       -> PWM_OUT=0, DUTY_NOW=0, BUSY=0 without waiting for a clock edge.
//  6. MOTOR_PWM_RAMP_EN undefined, EN_IN=1, DUTY_TARGET=200
//       -> DUTY_NOW=200 after the first period boundary.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM ramp block.
// Contents: FSM state encoding, duty width, last PWM phase value, and the
// saturating ramp step helper used when MOTOR_PWM_RAMP_EN is defined.
package motor_pkg;

    localparam int unsigned DUTY_W = 8;
    localparam logic [7:0]  PHASE_MAX = 8'd254;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    // One ramp step from cur toward dst, never overshooting dst. The 9-bit
    // intermediates keep cur+step and cur-step from wrapping.
    function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] dst,
                                                      input logic [DUTY_W-1:0] step);
        logic [DUTY_W:0]   up;
        logic [DUTY_W:0]   dn;
        logic [DUTY_W-1:0] res;
        up  = {1'b0, cur} + {1'b0, step};
        dn  = {1'b0, cur} - {1'b0, step};
        res = cur;
        if (cur < dst) begin
            res = (up > {1'b0, dst}) ? dst : up[DUTY_W-1:0];
        end else if (cur > dst) begin
            res = (dn[DUTY_W] || (dn[DUTY_W-1:0] < dst)) ? dst : dn[DUTY_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM generator: prescaler, 0..254 phase counter, period-boundary duty latch
// and registered compare.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   duty_now     duty to latch at the next period boundary
//   pwm_out      registered PWM, high while phase < latched duty
//   period_end   one-cycle strobe in the cycle the phase wraps 254 -> 0
module pwm_core
    import motor_pkg::*;
#(
    parameter int unsigned PRESCALE = 125
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty_now,
    output logic              pwm_out,
    output logic              period_end
);

    localparam int unsigned TICK_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        phase_q, phase_d;
    logic [DUTY_W-1:0] duty_lat_q, duty_lat_d;
    logic              pwm_q, pwm_d;
    logic              tick_wrap;

    assign tick_wrap  = (tick_q == TICK_W'(PRESCALE - 1));
    assign period_end = tick_wrap && (phase_q == PHASE_MAX);

    always_comb begin
        tick_d     = tick_wrap ? '0 : tick_q + TICK_W'(1);
        phase_d    = phase_q;
        if (tick_wrap) begin
            phase_d = (phase_q == PHASE_MAX) ? 8'd0 : phase_q + 8'd1;
        end
        duty_lat_d = period_end ? duty_now : duty_lat_q;
        // Compare against next-state values so the registered output lines up
        // with the phase it describes; duty 255 never drops since phase <= 254.
        pwm_d      = (phase_d < duty_lat_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q     <= '0;
            phase_q    <= '0;
            duty_lat_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            phase_q    <= phase_d;
            duty_lat_q <= duty_lat_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/motor_pwm_ramp.sv
// H-bridge enable PWM with soft start/stop duty ramp and zero-duty direction
// gating.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en_in         run request
//   dir_in        requested direction
//   duty_target   target duty (0 = off, 255 = 100%)
//   pwm_out       bridge enable PWM
//   dir_out       bridge direction, only updated while duty_now == 0
//   duty_now      duty currently applied
//   busy          high in every state except IDLE
// Build option: MOTOR_PWM_RAMP_EN enables stepped ramping; without it duty
// jumps to its destination at the next period boundary.
module motor_pwm_ramp
    import motor_pkg::*;
#(
    parameter int unsigned       PRESCALE  = 125,
    parameter int unsigned       RAMP_DIV  = 4,
    parameter logic [DUTY_W-1:0] RAMP_STEP = 8'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic              dir_in,
    input  logic [DUTY_W-1:0] duty_target,
    output logic              pwm_out,
    output logic              dir_out,
    output logic [DUTY_W-1:0] duty_now,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic              period_end;
    logic              step_now;
    logic [DUTY_W-1:0] run_next;
    logic [DUTY_W-1:0] down_next;
    logic              abort;

    pwm_core #(
        .PRESCALE (PRESCALE)
    ) u_pwm_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .duty_now   (duty_q),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

`ifdef MOTOR_PWM_RAMP_EN
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             div_last;

    assign div_last = (div_q == DIV_W'(RAMP_DIV - 1));

    // Divider restarts from IDLE so every start sees a full RAMP_DIV wait.
    always_comb begin
        div_d = div_q;
        if (state_q == ST_IDLE) begin
            div_d = '0;
        end else if (period_end) begin
            div_d = div_last ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign step_now  = period_end && div_last;
    assign run_next  = ramp_toward(duty_q, duty_target, RAMP_STEP);
    assign down_next = ramp_toward(duty_q, '0, RAMP_STEP);
`else
    // Ramp parameters have no effect when ramping is compiled out.
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{RAMP_STEP, 32'(RAMP_DIV)};

    assign step_now  = period_end;
    assign run_next  = duty_target;
    assign down_next = '0;
`endif

    assign abort = !en_in || (dir_in != dir_q) || (duty_target == '0);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                duty_d = '0;
                // Direction is only taken here, where duty is known to be 0.
                if (en_in && (duty_target != '0)) begin
                    dir_d   = dir_in;
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP, ST_RUN: begin
                if (abort) begin
                    state_d = ST_RAMP_DOWN;
                end else begin
                    if (step_now) begin
                        duty_d = run_next;
                    end
                    if ((state_q == ST_RAMP_UP) && (duty_d == duty_target)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (step_now) begin
                    duty_d = down_next;
                end
                if (duty_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
        end
    end

    assign dir_out  = dir_q;
    assign duty_now = duty_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Bench for motor_pwm_ramp: two instances (ramp step 1 and ramp step 100) run
// against a cycle-level reference model; directed scenarios followed by random
// stimulus. Expected duty sequences adapt to whether MOTOR_PWM_RAMP_EN is set.
module tb_motor_pwm_ramp;

    localparam int PERIOD = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] tgt0 = 8'd0;
    logic [7:0] tgt1 = 8'd0;

    logic       pwm0, dir0, busy0;
    logic [7:0] duty0;
    logic       pwm1, dir1, busy1;
    logic [7:0] duty1;

    always #5 clk = ~clk;

    motor_pwm_ramp #(
        .PRESCALE  (1),
        .RAMP_DIV  (1),
        .RAMP_STEP (8'd1)
    ) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_in       (en),
        .dir_in      (dir),
        .duty_target (tgt0),
        .pwm_out     (pwm0),
        .dir_out     (dir0),
        .duty_now    (duty0),
        .busy        (busy0)
    );

    motor_pwm_ramp #(
        .PRESCALE  (1),
        .RAMP_DIV  (1),
        .RAMP_STEP (8'd100)
    ) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_in       (en),
        .dir_in      (dir),
        .duty_target (tgt1),
        .pwm_out     (pwm1),
        .dir_out     (dir1),
        .duty_now    (duty1),
        .busy        (busy1)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 ramping up, 2 running, 3 ramping down
    int m_mode[2] = '{0, 0};
    int m_duty[2] = '{0, 0};
    int m_dir[2]  = '{0, 0};
    int m_lat[2]  = '{0, 0};
    int m_step[2] = '{1, 100};
    int m_ph      = 0;

    function automatic int step_to(input int cur, input int dst, input int st);
`ifdef MOTOR_PWM_RAMP_EN
        if (cur < dst) return (cur + st > dst) ? dst : cur + st;
        if (cur > dst) return (cur - st < dst) ? dst : cur - st;
        return cur;
`else
        if (st < 0) return cur;
        return dst;
`endif
    endfunction

    initial begin
        int b, t, dreq;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_mode[i] = 0; m_duty[i] = 0; m_dir[i] = 0; m_lat[i] = 0;
                end
                m_ph = 0;
            end else begin
                b    = (m_ph == PERIOD - 1) ? 1 : 0;
                dreq = dir ? 1 : 0;
                for (int i = 0; i < 2; i++) begin
                    t = (i == 0) ? int'(tgt0) : int'(tgt1);
                    if (b != 0) m_lat[i] = m_duty[i];
                    case (m_mode[i])
                        0: if (en && t != 0) begin
                            m_dir[i]  = dreq;
                            m_mode[i] = 1;
                        end
                        1, 2: begin
                            if (!en || dreq != m_dir[i] || t == 0) begin
                                m_mode[i] = 3;
                            end else begin
                                if (b != 0) m_duty[i] = step_to(m_duty[i], t, m_step[i]);
                                if (m_mode[i] == 1 && m_duty[i] == t) m_mode[i] = 2;
                            end
                        end
                        default: begin
                            if (b != 0) m_duty[i] = step_to(m_duty[i], 0, m_step[i]);
                            if (m_duty[i] == 0) m_mode[i] = 0;
                        end
                    endcase
                end
                m_ph = (b != 0) ? 0 : m_ph + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && rst_n) begin
                check("m0_duty", int'(duty0), m_duty[0]);
                check("m0_busy", int'(busy0), (m_mode[0] != 0) ? 1 : 0);
                check("m0_dir",  int'(dir0),  m_dir[0]);
                check("m0_pwm",  int'(pwm0),  (m_ph < m_lat[0]) ? 1 : 0);
                check("m1_duty", int'(duty1), m_duty[1]);
                check("m1_busy", int'(busy1), (m_mode[1] != 0) ? 1 : 0);
                check("m1_dir",  int'(dir1),  m_dir[1]);
                check("m1_pwm",  int'(pwm1),  (m_ph < m_lat[1]) ? 1 : 0);
            end
        end
    end

    // ---------------- helpers ----------------
    int seq_q[$];
    int dir_flips;
    int dir_flip_duty;
    int saw_idle;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Records each change of duty_now on one instance over ncyc cycles.
    task automatic record(input int inst, input int ncyc);
        int last, v, last_dir;
        seq_q.delete();
        dir_flips = 0; dir_flip_duty = -1; saw_idle = 0;
        last     = (inst == 0) ? int'(duty0) : int'(duty1);
        last_dir = (inst == 0) ? int'(dir0)  : int'(dir1);
        repeat (ncyc) begin
            @(negedge clk);
            v = (inst == 0) ? int'(duty0) : int'(duty1);
            if (v != last) begin
                seq_q.push_back(v);
                last = v;
            end
            if (((inst == 0) ? int'(dir0) : int'(dir1)) != last_dir) begin
                dir_flips++;
                dir_flip_duty = v;
                last_dir = (inst == 0) ? int'(dir0) : int'(dir1);
            end
            if (((inst == 0) ? busy0 : busy1) == 1'b0) saw_idle = 1;
        end
    endtask

    task automatic check_seq(input string tag, input int exp_q[$]);
        check({tag, "_len"}, seq_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seq_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), seq_q[i], exp_q[i]);
        end
    endtask

    task automatic count_high(input int inst, output int n);
        n = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if (((inst == 0) ? pwm0 : pwm1) == 1'b1) n++;
        end
    endtask

    initial begin
        int exp1[$], exp2[$], exp3[$];
        int n, budget;
`ifdef MOTOR_PWM_RAMP_EN
        exp1 = '{1, 2, 3, 4};
        exp2 = '{3, 2, 1, 0, 1, 2, 3, 4};
        exp3 = '{100, 200, 255};
`else
        exp1 = '{4};
        exp2 = '{0, 4};
        exp3 = '{255};
`endif
        // Reset state
        cycles(3);
        check("rst_pwm",  int'(pwm0),  0);
        check("rst_dir",  int'(dir0),  0);
        check("rst_duty", int'(duty0), 0);
        check("rst_busy", int'(busy0), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // 1: soft start to 4
        en = 1'b1; tgt0 = 8'd4;
        record(0, 5 * PERIOD + 10);
        check_seq("t1_seq", exp1);
        check("t1_busy", int'(busy0), 1);
        count_high(0, n);
        check("t1_high", n, 4);

        // 2: direction reversal passes through zero duty and IDLE
        dir = 1'b1;
        record(0, 10 * PERIOD + 10);
        check_seq("t2_seq", exp2);
        check("t2_flips", dir_flips, 1);
        check("t2_flip_duty", dir_flip_duty, 0);
        check("t2_idle", saw_idle, 1);
        check("t2_dir", int'(dir0), 1);

        // 3: large step saturates at 255, PWM constantly high
        tgt1 = 8'd255;
        record(1, 5 * PERIOD + 10);
        check_seq("t3_seq", exp3);
        count_high(1, n);
        check("t3_high", n, 255);

        // 4: enable drops together with a direction change
        en = 1'b0; dir = 1'b0;
        budget = 12 * PERIOD;
        while (busy0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("t4_timeout", (budget > 0) ? 1 : 0, 1);
        check("t4_duty", int'(duty0), 0);
        check("t4_busy", int'(busy0), 0);
        cycles(2 * PERIOD);
        check("t4_dir", int'(dir0), 1);

        // 5: asynchronous reset mid-run
        en = 1'b1;
        cycles(8 * PERIOD);
        check("t5_pre_pwm", int'(pwm1), 1);
        check("t5_pre_busy", int'(busy0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_pwm1",  int'(pwm1),  0);
        check("t5_duty0", int'(duty0), 0);
        check("t5_duty1", int'(duty1), 0);
        check("t5_busy0", int'(busy0), 0);
        check("t5_busy1", int'(busy1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus, checked cycle by cycle against the model
        for (int k = 0; k < 30; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            dir  = $urandom_range(0, 1);
            tgt0 = 8'($urandom_range(0, 6));
            tgt1 = 8'($urandom_range(0, 255));
            cycles($urandom_range(50, 900));
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
